// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT stage scheduler: conf type, the eight-pass
// configuration program, FSM state encoding and error codes.
package ntt_pkg;

    localparam int CONF_W   = 4;
    localparam int PROG_LEN = 8;

    typedef logic [CONF_W-1:0] conf_t;

    // Entry 0 is the leftmost element: pass order 1,3,2,4,5,8,6,7
    localparam conf_t [0:PROG_LEN-1] PROGRAM = {
        4'd1, 4'd3, 4'd2, 4'd4, 4'd5, 4'd8, 4'd6, 4'd7
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_DATAPATH = 2'b10;

endpackage

// File: rtl/ntt_conf_sequencer_pass_timer.sv
// Loadable up-counter with a terminal-count flag; shared between the pass
// timeout and the inter-pass gap.
module pass_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == term);

endmodule

// File: rtl/ntt_conf_sequencer.sv
// Drives top_stage's conf input through the eight-pass NTT program, advancing
// on completion edges, inserting idle gaps and trapping timeout/datapath errors.
module ntt_conf_sequencer #(
    parameter int CONF_W  = ntt_pkg::CONF_W,
    parameter int NSTEPS  = 8,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        done_flag,
    output logic [CONF_W-1:0] conf,
    output logic [2:0]        step,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    import ntt_pkg::*;

    localparam int TW = $clog2(TIMEOUT);

    state_t            state_reg;
    logic [CONF_W-1:0] conf_reg;
    logic [2:0]        step_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic [1:0]        err_code_reg;
    logic              edge_reg;

    logic              completion;
    logic              timer_load;
    logic              timer_en;
    logic [TW-1:0]     timer_term;
    logic              timer_tc;

    assign completion = done_flag[0] & ~edge_reg;

    // The timer is cleared on ISSUE and again on the completion edge, so the
    // gap count starts from zero on the first GAP cycle.
    always_comb begin
        timer_load = 1'b0;
        timer_en   = 1'b0;
        timer_term = TW'(TIMEOUT - 1);
        case (state_reg)
            S_ISSUE: timer_load = 1'b1;
            S_WAIT: begin
                timer_en   = 1'b1;
                timer_load = completion;
            end
            S_GAP: begin
                timer_en   = 1'b1;
                timer_term = TW'(GAP - 1);
            end
            default: ;
        endcase
    end

    pass_timer #(
        .W(TW)
    ) u_pass_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val ('0),
        .en       (timer_en),
        .term     (timer_term),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            conf_reg     <= '0;
            step_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
            edge_reg     <= 1'b0;
        end else begin
            edge_reg <= done_flag[0];
            if (abort) begin
                state_reg <= S_IDLE;
                conf_reg  <= '0;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE, S_ERR: begin
                        done_reg <= 1'b0;
                        conf_reg <= '0;
                        if (start) begin
                            state_reg    <= S_ISSUE;
                            step_reg     <= '0;
                            busy_reg     <= 1'b1;
                            err_reg      <= 1'b0;
                            err_code_reg <= ERR_NONE;
                        end
                    end
                    S_ISSUE: begin
                        conf_reg  <= CONF_W'(PROGRAM[step_reg]);
                        state_reg <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (completion) begin
                            conf_reg  <= '0;
                            state_reg <= S_GAP;
                        end else if (done_flag[1] || timer_tc) begin
                            conf_reg     <= '0;
                            busy_reg     <= 1'b0;
                            err_reg      <= 1'b1;
                            err_code_reg <= done_flag[1] ? ERR_DATAPATH : ERR_TIMEOUT;
                            state_reg    <= S_ERR;
                        end
                    end
                    S_GAP: begin
                        if (timer_tc) begin
                            if (step_reg == 3'(NSTEPS - 1)) begin
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                state_reg <= S_DONE;
                            end else begin
                                step_reg  <= step_reg + 3'd1;
                                state_reg <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign conf     = conf_reg;
    assign step     = step_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;

endmodule

// File: tb/tb_ntt_conf_sequencer.sv
// Directed bench for ntt_conf_sequencer: inputs driven and outputs sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_ntt_conf_sequencer;

    localparam int CONF_W  = 4;
    localparam int NSTEPS  = 8;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        done_flag = 2'b00;
    logic [CONF_W-1:0] conf;
    logic [2:0]        step;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    int checks = 0;
    int errors = 0;
    int prog [8] = '{1, 3, 2, 4, 5, 8, 6, 7};
    int c;

    ntt_conf_sequencer #(
        .CONF_W(CONF_W), .NSTEPS(NSTEPS), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .done_flag(done_flag), .conf(conf), .step(step), .busy(busy),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Ticks until conf is non-zero; returns the number of ticks taken.
    task automatic wait_conf(output int cycles);
        cycles = 0;
        while (conf == '0 && cycles < 40) begin
            tick();
            cycles++;
        end
        chk("wait_conf_bound", 32'(conf != '0), 32'd1);
    endtask

    task automatic finish_pass();
        repeat (3) tick();
        done_flag = 2'b01;
        tick();
        done_flag = 2'b00;
        chk("pass_conf_zero", 32'(conf), 32'd0);
    endtask

    // start sampled at the next edge; ISSUE one edge later loads PROGRAM[0]
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_conf_lat", 32'(conf), 32'd0);
        chk("start_err_clr", 32'(err), 32'd0);
        chk("start_code_clr", 32'(err_code), 32'd0);
        tick();
        chk("start_conf", 32'(conf), 32'd1);
        chk("start_step", 32'(step), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick();
        chk("rst_conf", 32'(conf), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        rst = 1'b1;
        tick();

        // Nominal run: completion 50 cycles after each pass's conf appears
        do_start();
        for (int p = 0; p < 8; p++) begin
            chk("nom_conf", 32'(conf), 32'(prog[p]));
            chk("nom_step", 32'(step), 32'(p));
            repeat (50) tick();
            chk("nom_hold", 32'(conf), 32'(prog[p]));
            chk("nom_busy", 32'(busy), 32'd1);
            done_flag = 2'b01;
            tick();
            done_flag = 2'b00;
            chk("nom_conf_zero", 32'(conf), 32'd0);
            if (p < 7) begin
                wait_conf(c);
                // GAP idle cycles plus the ISSUE cycle before conf reloads
                chk("nom_gap", 32'(c), 32'(GAP + 1));
            end
        end
        tick();
        chk("nom_done_early", 32'(done), 32'd0);
        tick();
        chk("nom_done", 32'(done), 32'd1);
        chk("nom_busy_fall", 32'(busy), 32'd0);
        tick();
        chk("nom_done_once", 32'(done), 32'd0);
        chk("nom_idle_conf", 32'(conf), 32'd0);

        // Stale flag: done_flag[0] held high into the next pass
        do_start();
        repeat (3) tick();
        done_flag = 2'b01;
        tick();
        chk("stale_gap", 32'(conf), 32'd0);
        wait_conf(c);
        chk("stale_conf", 32'(conf), 32'd3);
        repeat (10) tick();
        chk("stale_hold", 32'(conf), 32'd3);
        chk("stale_step", 32'(step), 32'd1);
        done_flag = 2'b00;
        tick();
        done_flag = 2'b01;
        tick();
        done_flag = 2'b00;
        chk("stale_adv", 32'(conf), 32'd0);
        wait_conf(c);
        chk("stale_next", 32'(conf), 32'd2);

        // Abort coincident with a completion edge
        repeat (3) tick();
        done_flag = 2'b01;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        done_flag = 2'b00;
        chk("abort_conf", 32'(conf), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        tick();
        chk("abort_stay", 32'(conf), 32'd0);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        tick();
        chk("sa_conf", 32'(conf), 32'd0);

        // Timeout on pass 3, with an ignored start during WAIT
        do_start();
        finish_pass();
        wait_conf(c);
        finish_pass();
        wait_conf(c);
        chk("to_conf", 32'(conf), 32'd2);
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_step", 32'(step), 32'd2);
        chk("ign_conf", 32'(conf), 32'd2);
        repeat (TIMEOUT - 102) tick();
        chk("to_not_yet", 32'(err), 32'd0);
        chk("to_conf_hold", 32'(conf), 32'd2);
        tick();
        chk("to_err", 32'(err), 32'd1);
        chk("to_code", 32'(err_code), 32'd1);
        chk("to_conf_zero", 32'(conf), 32'd0);
        chk("to_step", 32'(step), 32'd2);
        chk("to_busy", 32'(busy), 32'd0);

        // abort from ERR keeps the sticky flag
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_err_kept", 32'(err), 32'd1);
        chk("abort_code_kept", 32'(err_code), 32'd1);

        // Datapath error during pass 5
        do_start();
        for (int p = 1; p < 5; p++) begin
            finish_pass();
            wait_conf(c);
        end
        chk("dp_conf", 32'(conf), 32'd5);
        repeat (5) tick();
        done_flag = 2'b10;
        tick();
        done_flag = 2'b00;
        chk("dp_err", 32'(err), 32'd1);
        chk("dp_code", 32'(err_code), 32'd2);
        chk("dp_conf_zero", 32'(conf), 32'd0);
        chk("dp_step", 32'(step), 32'd4);
        tick();
        do_start();

        // Asynchronous reset in the middle of WAIT
        finish_pass();
        wait_conf(c);
        chk("pre_rst_conf", 32'(conf), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("arst_conf", 32'(conf), 32'd0);
        chk("arst_step", 32'(step), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_code", 32'(err_code), 32'd0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("no_resume_conf", 32'(conf), 32'd0);
        chk("no_resume_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
